// File: rtl/and_gate_b_if.sv
// Bus bundle for and_gate_b: operands driven by the master, gate results returned by the slave.
interface and_gate_b_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             all_ones;
    logic             rise;
    logic [CNT_W-1:0] hi_count;

    modport master (
        output a, b,
        input  y, y_q, all_ones, rise, hi_count
    );

    modport slave (
        input  a, b,
        output y, y_q, all_ones, rise, hi_count
    );
endinterface

// File: rtl/and_gate_b.sv
// Bitwise AND with a registered copy, an all-ones flag, a 0->1 edge pulse
// and a saturating count of cycles spent with the flag set.
module and_gate_b #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    and_gate_b_if.slave  agb
);

    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             all_ones_d;
    logic             all_ones_q;
    logic             rise_d;
    logic             rise_q;
    logic [CNT_W-1:0] hi_count_d;
    logic [CNT_W-1:0] hi_count_q;

    // Counter holds at its maximum rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end else begin
            return cnt + CNT_W'(1'b1);
        end
    endfunction

    // Gate output and next-state values for all registers.
    always_comb begin
        y_s        = agb.a & agb.b;
        y_d        = y_s;
        all_ones_d = &y_s;
        rise_d     = all_ones_d & ~all_ones_q;
        if (all_ones_q) begin
            hi_count_d = sat_inc(hi_count_q);
        end else begin
            hi_count_d = hi_count_q;
        end
    end

    // State registers, cleared immediately on reset assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q        <= {WIDTH{1'b0}};
            all_ones_q <= 1'b0;
            rise_q     <= 1'b0;
            hi_count_q <= {CNT_W{1'b0}};
        end else begin
            y_q        <= y_d;
            all_ones_q <= all_ones_d;
            rise_q     <= rise_d;
            hi_count_q <= hi_count_d;
        end
    end

    assign agb.y        = y_s;
    assign agb.y_q      = y_q;
    assign agb.all_ones = all_ones_q;
    assign agb.rise     = rise_q;
    assign agb.hi_count = hi_count_q;

endmodule

// File: tb/tb_and_gate_b.sv
// Directed bench for and_gate_b: default, narrow-counter and 4-bit instances share clock and reset.
module tb_and_gate_b;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    and_gate_b_if #(.WIDTH(1), .CNT_W(8)) if_def ();
    and_gate_b_if #(.WIDTH(1), .CNT_W(2)) if_sat ();
    and_gate_b_if #(.WIDTH(4), .CNT_W(8)) if_w4 ();

    and_gate_b #(.WIDTH(1), .CNT_W(8)) u_def (.clk(clk), .rst_n(rst_n), .agb(if_def));
    and_gate_b #(.WIDTH(1), .CNT_W(2)) u_sat (.clk(clk), .rst_n(rst_n), .agb(if_sat));
    and_gate_b #(.WIDTH(4), .CNT_W(8)) u_w4  (.clk(clk), .rst_n(rst_n), .agb(if_w4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic b;
        logic y;
    } tt_t;

    typedef struct {
        logic a;
        logic b;
        logic yq;
        logic ao;
        logic rs;
        int   hd;
        int   hs;
    } vec_t;

    tt_t  tt[4];
    vec_t seq[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive1(input logic a, input logic b);
        if_def.a = a;
        if_def.b = b;
        if_sat.a = a;
        if_sat.b = b;
    endtask

    task automatic check_regs1(input string tag, input logic yq, input logic ao, input logic rs,
                               input int hd, input int hs);
        check({tag, ".def.y_q"},      32'(if_def.y_q),      32'(yq));
        check({tag, ".def.all_ones"}, 32'(if_def.all_ones), 32'(ao));
        check({tag, ".def.rise"},     32'(if_def.rise),     32'(rs));
        check({tag, ".def.hi_count"}, 32'(if_def.hi_count), 32'(hd));
        check({tag, ".sat.y_q"},      32'(if_sat.y_q),      32'(yq));
        check({tag, ".sat.all_ones"}, 32'(if_sat.all_ones), 32'(ao));
        check({tag, ".sat.rise"},     32'(if_sat.rise),     32'(rs));
        check({tag, ".sat.hi_count"}, 32'(if_sat.hi_count), 32'(hs));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        tt[0] = '{1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b1, 1'b0};
        tt[2] = '{1'b1, 1'b0, 1'b0};
        tt[3] = '{1'b1, 1'b1, 1'b1};

        // a, b -> y_q, all_ones, rise, hi_count(CNT_W=8), hi_count(CNT_W=2)
        seq[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
        seq[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1};
        seq[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 2};
        seq[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3, 3};
        seq[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4, 3};
        seq[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5, 3};
        seq[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6, 3};
        seq[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6, 3};
        seq[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 3};
        seq[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7, 3};
        seq[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 3};
        seq[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 3};

        rst_n   = 1'b0;
        drive1(1'b1, 1'b1);
        if_w4.a = 4'b0000;
        if_w4.b = 4'b0000;
        edge_step();
        check("rst.def.y", 32'(if_def.y), 32'd1);
        check_regs1("rst", 1'b0, 1'b0, 1'b0, 0, 0);
        check("rst.w4.hi_count", 32'(if_w4.hi_count), 32'd0);

        // Truth table with reset held: y follows inputs, registers stay clear.
        for (int i = 0; i < 4; i++) begin
            drive1(tt[i].a, tt[i].b);
            #1;
            check($sformatf("tt%0d.y", i), 32'(if_def.y), 32'(tt[i].y));
            check($sformatf("tt%0d.y_q", i), 32'(if_def.y_q), 32'd0);
            #49;
        end

        // Release with operands low: no rise from reset release alone.
        @(negedge clk);
        drive1(1'b0, 1'b0);
        rst_n = 1'b1;
        edge_step();
        check_regs1("rel", 1'b0, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            drive1(seq[i].a, seq[i].b);
            edge_step();
            check_regs1($sformatf("seq%0d", i), seq[i].yq, seq[i].ao, seq[i].rs, seq[i].hd, seq[i].hs);
        end

        // Mid-cycle input change does not reach registers; async reset during rise pulse at saturation.
        drive1(1'b1, 1'b1);
        edge_step();
        check_regs1("pre", 1'b1, 1'b1, 1'b1, 8, 3);
        drive1(1'b1, 1'b0);
        #1;
        check("mid.y", 32'(if_def.y), 32'd0);
        check_regs1("mid", 1'b1, 1'b1, 1'b1, 8, 3);
        rst_n = 1'b0;
        #1;
        check_regs1("arst", 1'b0, 1'b0, 1'b0, 0, 0);
        check("arst.y0", 32'(if_def.y), 32'd0);
        drive1(1'b1, 1'b1);
        #1;
        check("arst.y1", 32'(if_sat.y), 32'd1);
        check_regs1("arst2", 1'b0, 1'b0, 1'b0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        edge_step();
        check_regs1("fresh1", 1'b1, 1'b1, 1'b1, 0, 0);
        edge_step();
        check_regs1("fresh2", 1'b1, 1'b1, 1'b0, 1, 1);

        // Four-bit instance.
        if_w4.a = 4'b1100;
        if_w4.b = 4'b1010;
        #1;
        check("w4.y_mix", 32'(if_w4.y), 32'h8);
        if_w4.a = 4'b1111;
        if_w4.b = 4'b1011;
        #1;
        check("w4.y", 32'(if_w4.y), 32'hB);
        edge_step();
        check("w4.y_q", 32'(if_w4.y_q), 32'hB);
        check("w4.ao0", 32'(if_w4.all_ones), 32'd0);
        check("w4.rise0", 32'(if_w4.rise), 32'd0);
        if_w4.b = 4'b1111;
        edge_step();
        check("w4.y_q1", 32'(if_w4.y_q), 32'hF);
        check("w4.ao1", 32'(if_w4.all_ones), 32'd1);
        check("w4.rise1", 32'(if_w4.rise), 32'd1);
        check("w4.hc0", 32'(if_w4.hi_count), 32'd0);
        edge_step();
        check("w4.rise2", 32'(if_w4.rise), 32'd0);
        check("w4.hc1", 32'(if_w4.hi_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/and_gate_b.md
AND_GATE_B -- requirements
Module: and_gate_b

Interface
REQ-001 Parameter WIDTH, default 1: bit width of operands a, b and result y.
REQ-002 Parameter CNT_W, default 8: width of the saturating high-cycle counter.
REQ-003 clk  input  1  single clock; all sequential logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset; assertion acts immediately, release synchronous to clk.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 y  output  WIDTH  combinational bitwise AND, y = a & b.
REQ-008 y_q  output  WIDTH  registered copy of y.
REQ-009 all_ones  output  1  registered, 1 when every bit of y_q's source (a & b) was 1 at last edge.
REQ-010 rise  output  1  one-cycle pulse on all_ones 0->1 transition.
REQ-011 hi_count  output  CNT_W  saturating count of clock cycles with all_ones = 1.

Function
REQ-012 y SHALL equal a & b bitwise at all times, zero clock latency, independent of clk and rst_n.
REQ-013 y SHALL settle within the same delta as any change of a or b; no latches, no X propagation from reset.
REQ-014 y_q SHALL load a & b on every rising clk edge while rst_n = 1; latency 1 cycle.
REQ-015 all_ones SHALL load &(a & b) (reduction AND of y) on every rising edge while rst_n = 1.
REQ-016 rise SHALL be 1 for exactly one cycle when all_ones registered value goes 0->1; 0 otherwise, including while all_ones stays 1.
REQ-017 hi_count SHALL increment by 1 on each rising edge where all_ones currently equals 1.
REQ-018 hi_count SHALL saturate at 2^CNT_W-1 and hold; no wrap-around.
REQ-019 For WIDTH = 1, all_ones SHALL equal y_q.
REQ-020 Inputs changing between edges SHALL have no effect on registered outputs until the next rising edge.

Reset
REQ-021 While rst_n = 0: y_q = 0, all_ones = 0, rise = 0, hi_count = 0, asynchronously, regardless of clk.
REQ-022 y SHALL remain a & b during reset.
REQ-023 Reset asserted mid-operation (including at saturation or during a rise pulse) SHALL clear all registers immediately; first post-reset edge behaves as from a fresh start.
REQ-024 A rise pulse SHALL NOT be generated by reset release alone; only by all_ones 0->1 on a clocked update.

Verification
REQ-025 Truth table, WIDTH = 1: (a,b) = (0,0),(0,1),(1,0),(1,1), 50 time units each -> y = 0,0,0,1 immediately after each change.
REQ-026 Registered path: rst_n released, a=1,b=1 held -> y_q = 1 and all_ones = 1 after 1st edge, rise = 1 for that cycle only, hi_count = 1,2,3 on subsequent edges.
REQ-027 Saturation, CNT_W = 2: a=b=1 held 6 cycles -> hi_count reaches 3 and stays 3.
REQ-028 Async reset: drop rst_n between edges with hi_count = 3 -> y_q, all_ones, rise, hi_count = 0 before next edge; y still equals a & b.
REQ-029 WIDTH = 4: a=4'b1111, b=4'b1011 -> y = 4'b1011, all_ones = 0 after edge; then b=4'b1111 -> all_ones = 1, rise pulse 1 cycle.
REQ-030 Toggle: a=1, b alternating 1/0 each cycle -> rise pulses every second cycle, hi_count increments every second cycle.
